// File: rtl/butterfly_seq_ctrl.sv
// -----------------------------------------------------------------------------
// butterfly_seq_ctrl
// Sequencing controller for the FFT butterfly datapath. It takes NUM_IN signed
// operands from the switches, one per button press, and strobes each into a
// datapath operand slot. It then holds compute for COMPUTE_CYCLES cycles and
// finally steps NUM_OUT datapath results onto dataOut, one per press, ending
// with a one-cycle done pulse.
//
// Ports
//   Clock      in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high reset
//   ReadyIn    in   1      debounced push-button level (edge-detected here)
//   DataIn     in   WIDTH  signed operand from the switches
//   ResultIn   in   WIDTH  signed datapath result selected by resultSel
//   dataOut    out  WIDTH  operand being loaded / result being displayed
//   load       out  1      one-cycle strobe: datapath captures dataOut
//   loadSel    out  IW     operand slot index, valid while load=1
//   compute    out  1      high for exactly COMPUTE_CYCLES cycles
//   resultSel  out  OW     result index to the datapath result mux
//   outValid   out  1      dataOut currently shows a result
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse at end of sequence
// All outputs are registered.
// -----------------------------------------------------------------------------
module butterfly_seq_ctrl #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned NUM_IN         = 4,
    parameter int unsigned NUM_OUT        = 4,
    parameter int unsigned COMPUTE_CYCLES = 2,
    parameter int unsigned IW             = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
    parameter int unsigned OW             = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReadyIn,
    input  logic signed [WIDTH-1:0] DataIn,
    input  logic signed [WIDTH-1:0] ResultIn,
    output logic signed [WIDTH-1:0] dataOut,
    output logic                    load,
    output logic [IW-1:0]           loadSel,
    output logic                    compute,
    output logic [OW-1:0]           resultSel,
    output logic                    outValid,
    output logic                    busy,
    output logic                    done
);

    // Operand counter must reach NUM_IN; compute counter must reach COMPUTE_CYCLES.
    localparam int unsigned CW = $clog2(NUM_IN + 1);
    localparam int unsigned KW = $clog2(COMPUTE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_SHOW    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     in_cnt_q, in_cnt_d;
    logic [KW-1:0]     cyc_cnt_q, cyc_cnt_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              load_q, load_d;
    logic [IW-1:0]     load_sel_q, load_sel_d;
    logic              compute_q, compute_d;
    logic [OW-1:0]     result_sel_q, result_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    // Set when resultSel has just changed; the next cycle captures ResultIn.
    logic              capture_q, capture_d;

    logic              press_c;

    // One press per 0->1 transition of the button level.
    assign press_c = ReadyIn & ~ready_q;

    // State and output registers; reset preloads the edge register so a
    // button held through reset does not count as a press.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            cyc_cnt_q    <= '0;
            ready_q      <= 1'b1;
            data_q       <= '0;
            load_q       <= 1'b0;
            load_sel_q   <= '0;
            compute_q    <= 1'b0;
            result_sel_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            capture_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            ready_q      <= ready_d;
            data_q       <= data_d;
            load_q       <= load_d;
            load_sel_q   <= load_sel_d;
            compute_q    <= compute_d;
            result_sel_q <= result_sel_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            capture_q    <= capture_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        ready_d      = ReadyIn;
        data_d       = data_q;
        load_d       = 1'b0;
        load_sel_d   = load_sel_q;
        compute_d    = compute_q;
        result_sel_d = result_sel_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        capture_d    = capture_q;

        case (state_q)
            S_IDLE: begin
                if (press_c) begin
                    data_d     = DataIn;
                    load_d     = 1'b1;
                    load_sel_d = '0;
                    in_cnt_d   = CW'(1);
                    cyc_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = (NUM_IN == 1) ? S_COMPUTE : S_LOAD;
                end
            end

            S_LOAD: begin
                if (press_c) begin
                    data_d     = DataIn;
                    load_d     = 1'b1;
                    load_sel_d = IW'(in_cnt_q);
                    in_cnt_d   = in_cnt_q + CW'(1);
                    // Last operand detected before the increment.
                    if (in_cnt_q == CW'(NUM_IN - 1)) begin
                        state_d = S_COMPUTE;
                    end
                end
            end

            S_COMPUTE: begin
                // First COMPUTE cycle carries the last load strobe, so compute
                // rises one cycle later and never overlaps load.
                if (cyc_cnt_q != KW'(COMPUTE_CYCLES)) begin
                    compute_d = 1'b1;
                    cyc_cnt_d = cyc_cnt_q + KW'(1);
                end else begin
                    compute_d    = 1'b0;
                    cyc_cnt_d    = '0;
                    result_sel_d = '0;
                    capture_d    = 1'b1;
                    state_d      = S_SHOW;
                end
            end

            S_SHOW: begin
                if (capture_q) begin
                    data_d      = ResultIn;
                    out_valid_d = 1'b1;
                    capture_d   = 1'b0;
                end
                if (press_c) begin
                    // Terminal index detected before the increment.
                    if (result_sel_q == OW'(NUM_OUT - 1)) begin
                        data_d      = '0;
                        out_valid_d = 1'b0;
                        capture_d   = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        result_sel_d = result_sel_q + OW'(1);
                        capture_d    = 1'b1;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dataOut   = data_q;
    assign load      = load_q;
    assign loadSel   = load_sel_q;
    assign compute   = compute_q;
    assign resultSel = result_sel_q;
    assign outValid  = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_butterfly_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_butterfly_seq_ctrl
// Directed bench for butterfly_seq_ctrl: a per-cycle vector table for the
// default instance and a hand-written sequence for a WIDTH=12, NUM_IN=1,
// NUM_OUT=2, COMPUTE_CYCLES=5 instance. The datapath result mux is modelled
// as a lookup on the DUT's resultSel.
// -----------------------------------------------------------------------------
module tb_butterfly_seq_ctrl;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst1, rdy1;
    logic [7:0]  din1, res1, dout1;
    logic        load1, cmp1, ov1, busy1, done1;
    logic [1:0]  lsel1, rsel1;

    butterfly_seq_ctrl u_dut1 (
        .Clock     (clk),
        .Reset     (rst1),
        .ReadyIn   (rdy1),
        .DataIn    (din1),
        .ResultIn  (res1),
        .dataOut   (dout1),
        .load      (load1),
        .loadSel   (lsel1),
        .compute   (cmp1),
        .resultSel (rsel1),
        .outValid  (ov1),
        .busy      (busy1),
        .done      (done1)
    );

    // Datapath results 10, -10, 20, -20
    always_comb begin
        case (rsel1)
            2'd0:    res1 = 8'h0A;
            2'd1:    res1 = 8'hF6;
            2'd2:    res1 = 8'h14;
            default: res1 = 8'hEC;
        endcase
    end

    // Second instance
    logic        rst2, rdy2;
    logic [11:0] din2, res2, dout2;
    logic        load2, cmp2, ov2, busy2, done2;
    logic [0:0]  lsel2, rsel2;

    butterfly_seq_ctrl #(
        .WIDTH          (12),
        .NUM_IN         (1),
        .NUM_OUT        (2),
        .COMPUTE_CYCLES (5)
    ) u_dut2 (
        .Clock     (clk),
        .Reset     (rst2),
        .ReadyIn   (rdy2),
        .DataIn    (din2),
        .ResultIn  (res2),
        .dataOut   (dout2),
        .load      (load2),
        .loadSel   (lsel2),
        .compute   (cmp2),
        .resultSel (rsel2),
        .outValid  (ov2),
        .busy      (busy2),
        .done      (done2)
    );

    assign res2 = (rsel2 == 1'b0) ? 12'h123 : 12'hFFF;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [7:0] din;
        logic [7:0] dout;
        logic       ld;
        logic [1:0] lsel;
        logic       cmp;
        logic [1:0] rsel;
        logic       ov;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic rst, input logic rdy, input logic [7:0] din,
                       input logic [7:0] dout, input logic ld, input logic [1:0] lsel,
                       input logic cmp, input logic [1:0] rsel, input logic ov,
                       input logic bsy, input logic dn);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.din = din; v.dout = dout; v.ld = ld;
        v.lsel = lsel; v.cmp = cmp; v.rsel = rsel; v.ov = ov; v.bsy = bsy; v.dn = dn;
        vecs.push_back(v);
    endtask

    task automatic step2(input string nm, input logic rst, input logic rdy, input logic [11:0] din,
                         input logic [11:0] e_dout, input logic e_ld, input logic e_lsel,
                         input logic e_cmp, input logic e_rsel, input logic e_ov,
                         input logic e_bsy, input logic e_dn);
        logic [18:0] got, exp;
        rst2 = rst; rdy2 = rdy; din2 = din;
        @(posedge clk); #1;
        got = {dout2, load2, lsel2, cmp2, rsel2, ov2, busy2, done2};
        exp = {e_dout, e_ld, e_lsel, e_cmp, e_rsel, e_ov, e_bsy, e_dn};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got dout=%h load=%b lsel=%b comp=%b rsel=%b ov=%b busy=%b done=%b, expected dout=%h load=%b lsel=%b comp=%b rsel=%b ov=%b busy=%b done=%b",
                     nm, dout2, load2, lsel2, cmp2, rsel2, ov2, busy2, done2,
                     e_dout, e_ld, e_lsel, e_cmp, e_rsel, e_ov, e_bsy, e_dn);
        end
    endtask

    initial begin
        rst1 = 1'b1; rdy1 = 1'b1; din1 = 8'h00;
        rst2 = 1'b1; rdy2 = 1'b0; din2 = 12'h000;

        //   rst rdy din     dout  ld lsel cmp rsel ov bsy dn
        // Button held through reset: no press until released and pressed again
        add(1, 1, 8'h00,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 8'h00,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h05,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h05,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h05,  8'h05, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h05,  8'h05, 0, 0, 0, 0, 0, 1, 0);
        // Full sequence: operands 3,-2,7,-128
        add(1, 0, 8'h00,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h03,  8'h03, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h03,  8'h03, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'hFE,  8'hFE, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 8'hFE,  8'hFE, 0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 8'h07,  8'h07, 1, 2, 0, 0, 0, 1, 0);
        add(0, 0, 8'h07,  8'h07, 0, 2, 0, 0, 0, 1, 0);
        add(0, 1, 8'h80,  8'h80, 1, 3, 0, 0, 0, 1, 0);
        // Compute with the button toggling every cycle
        add(0, 0, 8'h55,  8'h80, 0, 3, 1, 0, 0, 1, 0);
        add(0, 1, 8'h55,  8'h80, 0, 3, 1, 0, 0, 1, 0);
        add(0, 0, 8'h55,  8'h80, 0, 3, 0, 0, 0, 1, 0);
        // Show results 10,-10,20,-20 then done
        add(0, 0, 8'h00,  8'h0A, 0, 3, 0, 0, 1, 1, 0);
        add(0, 1, 8'h00,  8'h0A, 0, 3, 0, 1, 1, 1, 0);
        add(0, 0, 8'h00,  8'hF6, 0, 3, 0, 1, 1, 1, 0);
        add(0, 1, 8'h00,  8'hF6, 0, 3, 0, 2, 1, 1, 0);
        add(0, 0, 8'h00,  8'h14, 0, 3, 0, 2, 1, 1, 0);
        add(0, 1, 8'h00,  8'h14, 0, 3, 0, 3, 1, 1, 0);
        add(0, 0, 8'h00,  8'hEC, 0, 3, 0, 3, 1, 1, 0);
        add(0, 1, 8'h00,  8'h00, 0, 3, 0, 3, 0, 1, 1);
        add(0, 0, 8'h00,  8'h00, 0, 3, 0, 3, 0, 0, 0);
        // Abort after the 2nd operand; reset beats a simultaneous press
        add(0, 1, 8'h01,  8'h01, 1, 0, 0, 3, 0, 1, 0);
        add(0, 0, 8'h01,  8'h01, 0, 0, 0, 3, 0, 1, 0);
        add(0, 1, 8'h02,  8'h02, 1, 1, 0, 3, 0, 1, 0);
        add(0, 0, 8'h02,  8'h02, 0, 1, 0, 3, 0, 1, 0);
        add(1, 1, 8'h09,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h09,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h09,  8'h00, 0, 0, 0, 0, 0, 0, 0);
        // Fresh sequence restarts at slot 0
        add(0, 1, 8'h04,  8'h04, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 8'h04,  8'h04, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h06,  8'h06, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 8'h06,  8'h06, 0, 1, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [16:0] got, exp;
            rst1 = vecs[i].rst; rdy1 = vecs[i].rdy; din1 = vecs[i].din;
            @(posedge clk); #1;
            got = {dout1, load1, lsel1, cmp1, rsel1, ov1, busy1, done1};
            exp = {vecs[i].dout, vecs[i].ld, vecs[i].lsel, vecs[i].cmp,
                   vecs[i].rsel, vecs[i].ov, vecs[i].bsy, vecs[i].dn};
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL vec%0d: got dout=%h load=%b lsel=%0d comp=%b rsel=%0d ov=%b busy=%b done=%b, expected dout=%h load=%b lsel=%0d comp=%b rsel=%0d ov=%b busy=%b done=%b",
                         i, dout1, load1, lsel1, cmp1, rsel1, ov1, busy1, done1,
                         vecs[i].dout, vecs[i].ld, vecs[i].lsel, vecs[i].cmp,
                         vecs[i].rsel, vecs[i].ov, vecs[i].bsy, vecs[i].dn);
            end
        end

        // Single-operand instance: load goes straight to a 5-cycle compute
        step2("i2_reset",    1, 1, 12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        step2("i2_idle",     0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        step2("i2_press",    0, 1, 12'h800, 12'h800, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step2($sformatf("i2_compute%0d", k), 0, 0, 12'h800, 12'h800, 0, 0, 1, 0, 0, 1, 0);
        end
        step2("i2_cmp_end",  0, 0, 12'h800, 12'h800, 0, 0, 0, 0, 0, 1, 0);
        step2("i2_show0",    0, 0, 12'h000, 12'h123, 0, 0, 0, 0, 1, 1, 0);
        step2("i2_press1",   0, 1, 12'h000, 12'h123, 0, 0, 0, 1, 1, 1, 0);
        step2("i2_show1",    0, 0, 12'h000, 12'hFFF, 0, 0, 0, 1, 1, 1, 0);
        step2("i2_done",     0, 1, 12'h000, 12'h000, 0, 0, 0, 1, 0, 1, 1);
        step2("i2_idle_end", 0, 0, 12'h000, 12'h000, 0, 0, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/butterfly_seq_ctrl.md
Name: butterfly_seq_ctrl

Overview:
- Parametrised sequencing controller for the FFT butterfly datapath.
- Collects NUM_IN signed operands from the switches, one per ReadyIn press, and strobes each into the datapath operand slot with an index.
- Then holds compute for COMPUTE_CYCLES cycles.
- Then steps NUM_OUT datapath results onto dataOut, one per press, and pulses done.
- Generalises the fixed IDLE/LOAD/COMPUTE/DONE controller to any width, operand count, result count and compute latency.

Parameters:
- WIDTH, 8: operand/result width, signed two's complement.
- NUM_IN, 4: operands per butterfly (Ar, Ai, Br, Bi); must be >= 1.
- NUM_OUT, 4: results per butterfly; must be >= 1.
- COMPUTE_CYCLES, 2: cycles compute is held high; must be >= 1.
- IW, $clog2(NUM_IN) (min 1): loadSel width.
- OW, $clog2(NUM_OUT) (min 1): resultSel width.

Ports:
- Clock  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReadyIn  in  1  level from the debounced push button; controller edge-detects it.
- DataIn  in  WIDTH  signed operand from the switches.
- ResultIn  in  WIDTH  signed datapath result selected by resultSel.
- dataOut  out  WIDTH  signed, registered. Operand being loaded during LOAD phase; displayed result during SHOW phase.
- load  out  1  one-cycle strobe: datapath captures dataOut into slot loadSel.
- loadSel  out  IW  operand slot index, valid while load=1.
- compute  out  1  high for exactly COMPUTE_CYCLES consecutive cycles.
- resultSel  out  OW  result index driven to the datapath mux.
- outValid  out  1  high while dataOut shows a result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (sync, Reset=1 at a Clock edge):
  - State goes to IDLE; all counters 0.
  - dataOut=0, load=0, loadSel=0, compute=0, resultSel=0, outValid=0, busy=0, done=0.
  - Edge register ReadyIn_q is set to 1, so a button held through reset generates no press.
  - Reset mid-sequence aborts immediately, with no done pulse; partially loaded operands are discarded.
- Press detect: rise = ReadyIn & ~ReadyIn_q; ReadyIn_q <= ReadyIn every cycle. Exactly one press per 0->1 transition.
- States: IDLE, LOAD, COMPUTE, SHOW, DONE. All outputs are registered.
- IDLE:
  - On a press at edge t: dataOut<=DataIn, load<=1, loadSel<=0, inCnt<=1. Go to LOAD, or to COMPUTE if NUM_IN==1.
  - load is therefore high during cycle t+1 only.
- LOAD:
  - On a press: dataOut<=DataIn, load<=1, loadSel<=inCnt, inCnt++.
  - When inCnt reaches NUM_IN-1 before increment (last operand), go to COMPUTE.
  - load defaults to 0 on every non-press cycle.
- COMPUTE:
  - compute=1 for exactly COMPUTE_CYCLES cycles, starting the cycle after the last load strobe (load and compute never overlap).
  - Presses during COMPUTE are ignored.
  - On the final compute cycle: resultSel<=0. Go to SHOW.
- SHOW:
  - First cycle: dataOut<=ResultIn (index 0). outValid is 1 from the following cycle onward.
  - Each press: resultSel++; one cycle later dataOut<=ResultIn for the new index.
  - A press while resultSel==NUM_OUT-1: outValid<=0, dataOut<=0, go to DONE.
  - Outside the capture cycle, dataOut holds its value.
- DONE: done=1 for one cycle, busy=1; then IDLE. A press during DONE is ignored.
- busy=1 from the cycle after the IDLE-exit press until the cycle done drops.
- Index arithmetic: inCnt and resultSel never wrap. Terminal states are detected before increment.
- dataOut is a pass-through of signed values: no sign extension or saturation.
- Reset has priority over any simultaneous press.

Test Plan:
- Reset with ReadyIn held 1, then release and press once with DataIn=8'sh05 -> no press registered during reset; after the press, load=1 for one cycle, loadSel=0, dataOut=5.
- Defaults; press 4 times with DataIn=3,-2,7,-128 -> four single-cycle load strobes, loadSel=0..3, dataOut=3,-2,7,-128 (8'h80). Then compute=1 for exactly 2 cycles, starting the cycle after the last strobe.
- After compute, ResultIn follows resultSel as 10,-10,20,-20; press 4 times -> dataOut=10,-10,20,-20 with outValid=1. The 4th press gives done=1 for one cycle, then busy=0.
- Press storm: ReadyIn toggled every cycle during COMPUTE -> no load, no resultSel change, compute still exactly COMPUTE_CYCLES cycles.
- Assert Reset after the 2nd operand load -> next cycle all outputs 0, state IDLE, no done. A fresh 4-press sequence starts again at loadSel=0.
- Instance with WIDTH=12, NUM_IN=1, NUM_OUT=2, COMPUTE_CYCLES=5, press with DataIn=-2048 -> load with loadSel=0, then compute for 5 cycles, then 2 results shown, then done.
